writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Shares the three ROB writeback ports (writeback1..3) among four result producers: ALU0, ALU1, load unit, branch/jalr unit.
- Each source has a small FIFO. Every cycle up to three FIFO heads are granted round-robin and driven, registered, onto the writeback ports.
- Sits between the execution units and reorder_buffer. The same port triples also feed the reservation-station / load-store-buffer wakeup.
- The ROB's reset_en (mispredict flush) discards all buffered results.

Parameters:
- DEPTH, 2, entries per source FIFO (power of two, at least 2).
- VREG_W, 5, width of the ROB tag (vregid).
- DATA_W, 32, width of the result value.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  ROB reset_en; discards all buffered and in-flight results
- src_valid  input  4  per-source result valid; bit i = source i (0=ALU0, 1=ALU1, 2=load, 3=branch)
- src_vregid  input  4*VREG_W  per-source ROB tag; source i at bits [i*VREG_W +: VREG_W]
- src_val  input  4*DATA_W  per-source result; source i at bits [i*DATA_W +: DATA_W]
- src_ready  output  4  per-source accept; a transfer happens when src_valid[i] && src_ready[i] at posedge
- writeback1_en  output  1  port 1 valid
- writeback1_vregid  output  VREG_W  port 1 tag
- writeback1_val  output  DATA_W  port 1 value
- writeback2_en, writeback2_vregid, writeback2_val  output  1/VREG_W/DATA_W  port 2
- writeback3_en, writeback3_vregid, writeback3_val  output  1/VREG_W/DATA_W  port 3

Behaviour:
- Reset (rst=1 at posedge):
  - All FIFOs empty.
  - rr_ptr=0.
  - writeback*_en=0; vregid/val outputs 0.
  - src_ready=all 1 from the next cycle.
- FIFO, per source:
  - Circular buffer with DEPTH entries, rd/wr pointers and a count (0..DEPTH).
  - Pointers wrap modulo DEPTH.
  - src_ready[i] = (count[i] != DEPTH). It depends on registered count only; there is no combinational path from src_valid or the grant.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at any count below DEPTH.
  - A source that presents valid while not ready holds its data; no drop and no overwrite.
- Grant, combinational each cycle from registered FIFO state:
  - Scan sources in order rr_ptr, rr_ptr+1, ... (mod 4).
  - The first non-empty FIFO gets port 1, the second port 2, the third port 3.
  - Each source pops at most one entry per cycle.
  - Unused ports get en=0.
  - If all four FIFOs are non-empty, exactly three pop; the skipped source is the one at position rr_ptr+3.
- Output:
  - Granted heads are registered onto the writeback ports at the posedge where they pop.
  - Minimum latency: a result accepted at edge t appears on a port during cycle t+1..t+2. It is visible after edge t+1, because it enters the FIFO at t and is granted/registered at t+1.
  - There is no bypass from src_* to the outputs.
  - Ports with en=0 hold their previous vregid/val; consumers must ignore them.
- Round-robin:
  - If any grant occurs, rr_ptr <= (index of last granted source + 1) mod 4.
  - Otherwise rr_ptr is unchanged.
  - Guarantees: every non-empty source is served within 2 cycles; no starvation.
- Flush (flush=1 at posedge):
  - All FIFOs emptied; a push in the same cycle is discarded.
  - No pop takes effect.
  - writeback*_en <= 0, so outputs are 0 in the following cycle.
  - rr_ptr <= 0.
  - Results registered onto the ports in the cycle before flush still appear once. The ROB ignores them because it flushes on the same edge.
- Precedence: rst and flush behave identically and override push/pop. Flush mid-stream leaves no partial state.
- Tags are not checked; duplicate or out-of-order tags pass through unmodified. Per-source order is preserved (FIFO). Cross-source order follows the grant.

Test Plan:
- Single source: after reset, ALU0 sends tag 3/val 0x1234 at edge t -> cycle after edge t+1: writeback1_en=1, vregid=3, val=0x1234; ports 2/3 en=0; src_ready stays 1.
- Four-way contention: all four FIFOs hold one entry each (tags 1,2,3,4), rr_ptr=0 -> next cycle ports 1/2/3 = tags 1/2/3; rr_ptr becomes 3; the following cycle port1 = tag 4, other ports en=0.
- Backpressure: load source pushes tags 5,6,7 on consecutive edges while other sources keep grants busy -> src_ready[2]=0 once count=2; tag 7 is held by the source and accepted later; output order 5,6,7 is preserved with no drop.
- Flush: two sources each hold 2 entries, flush pulsed together with a new push -> next cycle all en=0; src_ready=4'b1111; nothing from before the flush (including the same-cycle push) ever appears afterward; rr_ptr=0.
- Fairness/wrap: sources 0 and 3 both push every cycle for 10 cycles -> both drain at equal rates, neither FIFO overflows, and rr_ptr wraps through 3->0 correctly.
- Reset mid-operation: rst asserted with full FIFOs and active outputs -> next cycle all en=0, src_ready all 1, and later pushes behave as from power-up.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Bundle between the four result producers and the three ROB writeback ports.
// The arbiter sits on the slave side; producers and the ROB sit on the master side.
interface writeback_arbiter_if #(
    parameter int VREG_W = 5,
    parameter int DATA_W = 32
);
    logic [3:0]          src_valid;
    logic [4*VREG_W-1:0] src_vregid;
    logic [4*DATA_W-1:0] src_val;
    logic [3:0]          src_ready;

    logic                writeback1_en;
    logic [VREG_W-1:0]   writeback1_vregid;
    logic [DATA_W-1:0]   writeback1_val;
    logic                writeback2_en;
    logic [VREG_W-1:0]   writeback2_vregid;
    logic [DATA_W-1:0]   writeback2_val;
    logic                writeback3_en;
    logic [VREG_W-1:0]   writeback3_vregid;
    logic [DATA_W-1:0]   writeback3_val;

    modport master (
        output src_valid, src_vregid, src_val,
        input  src_ready,
        input  writeback1_en, writeback1_vregid, writeback1_val,
        input  writeback2_en, writeback2_vregid, writeback2_val,
        input  writeback3_en, writeback3_vregid, writeback3_val
    );

    modport slave (
        input  src_valid, src_vregid, src_val,
        output src_ready,
        output writeback1_en, writeback1_vregid, writeback1_val,
        output writeback2_en, writeback2_vregid, writeback2_val,
        output writeback3_en, writeback3_vregid, writeback3_val
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Four per-source result FIFOs feeding three registered ROB writeback ports.
// Up to three FIFO heads are granted each cycle in round-robin order from rr_ptr.
module writeback_arbiter #(
    parameter int DEPTH  = 2,
    parameter int VREG_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    writeback_arbiter_if.slave  bus
);
    localparam int N_SRC  = 4;
    localparam int N_PORT = 3;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [VREG_W-1:0] vregid;
        logic [DATA_W-1:0] val;
    } entry_t;

    entry_t           mem     [N_SRC][DEPTH];
    logic [PTR_W-1:0] rd_ptr  [N_SRC];
    logic [PTR_W-1:0] wr_ptr  [N_SRC];
    logic [CNT_W-1:0] count   [N_SRC];
    logic [1:0]       rr_ptr;

    logic [N_SRC-1:0]  ready;
    logic [N_SRC-1:0]  push;
    logic [N_SRC-1:0]  pop;
    logic [1:0]        port_src [N_PORT];
    logic [N_PORT-1:0] port_hit;
    logic [1:0]        last_src;

    entry_t            wb_q [N_PORT];
    logic [N_PORT-1:0] wb_en_q;
    logic              clear;

    // Flush is the ROB's mispredict recovery and behaves exactly like reset.
    assign clear = rst | flush;

    // Ready depends only on registered occupancy, never on valid or grant.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            ready[i] = (count[i] != FULL);
            push[i]  = bus.src_valid[i] && ready[i];
        end
    end

    // NOTE: blocking assignments here so n_grant/idx update within one scan;
    // every output gets a default first, so no latch is inferred.
    always_comb begin
        logic [1:0] idx;
        logic [1:0] n_grant;
        idx      = '0;
        n_grant  = '0;
        pop      = '0;
        port_hit = '0;
        last_src = rr_ptr;
        for (int p = 0; p < N_PORT; p++) port_src[p] = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = rr_ptr + 2'(k);
            if (count[idx] != '0 && n_grant != 2'd3) begin
                pop[idx]          = 1'b1;
                port_hit[n_grant] = 1'b1;
                port_src[n_grant] = idx;
                last_src          = idx;
                n_grant           = n_grant + 2'd1;
            end
        end
    end

    // NOTE: the storage array carries no reset; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i] && !clear) begin
                mem[i][wr_ptr[i]] <= '{vregid: bus.src_vregid[i*VREG_W +: VREG_W],
                                       val:    bus.src_val[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            rr_ptr  <= '0;
            wb_en_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            for (int p = 0; p < N_PORT; p++) wb_q[p] <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            // Idle ports keep their last payload; only the enable drops.
            for (int p = 0; p < N_PORT; p++) begin
                wb_en_q[p] <= port_hit[p];
                if (port_hit[p]) wb_q[p] <= mem[port_src[p]][rd_ptr[port_src[p]]];
            end
            if (|pop) rr_ptr <= last_src + 2'd1;
        end
    end

    assign bus.src_ready         = ready;
    assign bus.writeback1_en     = wb_en_q[0];
    assign bus.writeback1_vregid = wb_q[0].vregid;
    assign bus.writeback1_val    = wb_q[0].val;
    assign bus.writeback2_en     = wb_en_q[1];
    assign bus.writeback2_vregid = wb_q[1].vregid;
    assign bus.writeback2_val    = wb_q[1].val;
    assign bus.writeback3_en     = wb_en_q[2];
    assign bus.writeback3_vregid = wb_q[2].vregid;
    assign bus.writeback3_val    = wb_q[2].val;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: per-source expected queues are filled on
// accepted transfers and drained as results appear on the writeback ports.
module tb_writeback_arbiter;
    localparam int DEPTH  = 2;
    localparam int VREG_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [VREG_W-1:0] vregid;
        logic [DATA_W-1:0] val;
    } item_t;

    logic clk;
    logic rst;
    logic flush;

    writeback_arbiter_if #(.VREG_W(VREG_W), .DATA_W(DATA_W)) bus ();

    writeback_arbiter #(.DEPTH(DEPTH), .VREG_W(VREG_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    int    seq   = 0;
    item_t pend  [4][$];
    item_t exp_q [4][$];
    int    wait_cnt [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic item_t mk(input int s, input int tag);
        item_t it;
        seq++;
        it.vregid = VREG_W'(tag);
        it.val    = 32'hA000_0000 | 32'(s << 16) | 32'(seq);
        return it;
    endfunction

    task automatic read_port(input int p, output logic en, output item_t it);
        case (p)
            0:       begin en = bus.writeback1_en; it = {bus.writeback1_vregid, bus.writeback1_val}; end
            1:       begin en = bus.writeback2_en; it = {bus.writeback2_vregid, bus.writeback2_val}; end
            default: begin en = bus.writeback3_en; it = {bus.writeback3_vregid, bus.writeback3_val}; end
        endcase
    endtask

    task automatic check_port(input string tag, input int p, input logic en_e, input item_t it_e);
        logic  en;
        item_t it;
        read_port(p, en, it);
        check($sformatf("%s_wb%0d_en", tag, p + 1), 64'(en), 64'(en_e));
        if (en_e) begin
            check($sformatf("%s_wb%0d_vregid", tag, p + 1), 64'(it.vregid), 64'(it_e.vregid));
            check($sformatf("%s_wb%0d_val", tag, p + 1), 64'(it.val), 64'(it_e.val));
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int p = 0; p < 3; p++) begin
            logic  en;
            item_t it;
            read_port(p, en, it);
            check($sformatf("%s_wb%0d_en", tag, p + 1), 64'(en), 64'd0);
            check($sformatf("%s_wb%0d_data", tag, p + 1), 64'(it), 64'd0);
        end
    endtask

    function automatic int outstanding();
        int n = 0;
        for (int s = 0; s < 4; s++) n += pend[s].size() + exp_q[s].size();
        return n;
    endfunction

    // One clock: drive source heads, record accepted transfers, then score outputs.
    task automatic tick();
        logic [3:0] pre;
        logic [3:0] served;
        item_t      it;
        logic       en;
        int         hit;
        for (int s = 0; s < 4; s++) begin
            pre[s] = exp_q[s].size() > 0;
            if (pend[s].size() > 0) begin
                bus.src_valid[s]                    = 1'b1;
                bus.src_vregid[s*VREG_W +: VREG_W]  = pend[s][0].vregid;
                bus.src_val[s*DATA_W +: DATA_W]     = pend[s][0].val;
            end else begin
                bus.src_valid[s]                    = 1'b0;
                bus.src_vregid[s*VREG_W +: VREG_W]  = '0;
                bus.src_val[s*DATA_W +: DATA_W]     = '0;
            end
        end
        #1;
        for (int s = 0; s < 4; s++) begin
            if (bus.src_valid[s] && bus.src_ready[s] === 1'b1) begin
                it = pend[s].pop_front();
                if (!rst && !flush) exp_q[s].push_back(it);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (rst || flush) begin
            for (int s = 0; s < 4; s++) begin
                exp_q[s].delete();
                pend[s].delete();
                wait_cnt[s] = 0;
            end
        end
        served = '0;
        for (int p = 0; p < 3; p++) begin
            read_port(p, en, it);
            if (en === 1'b1) begin
                hit = -1;
                for (int s = 0; s < 4; s++)
                    if (hit < 0 && exp_q[s].size() > 0 && exp_q[s][0] == it) hit = s;
                check($sformatf("wb%0d_known_result vregid=%0d val=%0h", p + 1, it.vregid, it.val),
                      64'(hit >= 0), 64'd1);
                if (hit >= 0) begin
                    void'(exp_q[hit].pop_front());
                    served[hit] = 1'b1;
                end
            end
        end
        for (int s = 0; s < 4; s++)
            check($sformatf("src_ready[%0d]", s), 64'(bus.src_ready[s]), 64'(exp_q[s].size() != DEPTH));
        if (!rst && !flush) begin
            for (int s = 0; s < 4; s++) begin
                if (pre[s]) begin
                    wait_cnt[s] = served[s] ? 0 : wait_cnt[s] + 1;
                    check($sformatf("serve_wait[%0d]", s), 64'(wait_cnt[s] <= 1), 64'd1);
                end else begin
                    wait_cnt[s] = 0;
                end
            end
        end
    endtask

    initial begin
        item_t a0 [10];
        item_t a3 [10];
        item_t b0 [4];
        item_t b1 [4];
        item_t b3 [4];
        item_t t;

        rst = 1'b1;
        flush = 1'b0;
        bus.src_valid = '0;
        bus.src_vregid = '0;
        bus.src_val = '0;
        tick();
        tick();
        rst = 1'b0;
        check_cleared("reset");

        // Single source: visible one edge after the accepting edge, not before.
        t = '{vregid: 5'd3, val: 32'h0000_1234};
        pend[0].push_back(t);
        tick();
        check_port("single_t", 0, 1'b0, t);
        tick();
        check_port("single_t1", 0, 1'b1, t);
        check_port("single_t1", 1, 1'b0, t);
        check_port("single_t1", 2, 1'b0, t);

        // Four-way contention from rr_ptr=0.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int s = 0; s < 4; s++) pend[s].push_back(mk(s, s + 1));
        b0[0] = pend[0][0]; b1[0] = pend[1][0]; b3[0] = pend[3][0]; t = pend[2][0];
        tick();
        check_port("contend_fill", 0, 1'b0, t);
        tick();
        check_port("contend_a", 0, 1'b1, b0[0]);
        check_port("contend_a", 1, 1'b1, b1[0]);
        check_port("contend_a", 2, 1'b1, t);
        tick();
        check_port("contend_b", 0, 1'b1, b3[0]);
        check_port("contend_b", 1, 1'b0, t);
        check_port("contend_b", 2, 1'b0, t);

        // Backpressure on the load source: park rr_ptr at 3, then tags 5,6,7.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        t = mk(2, 9);
        pend[2].push_back(t);
        tick();
        tick();
        check_port("bp_warm", 0, 1'b1, t);
        for (int k = 0; k < 4; k++) begin
            b0[k] = mk(0, 10 + k); pend[0].push_back(b0[k]);
            b1[k] = mk(1, 14 + k); pend[1].push_back(b1[k]);
            b3[k] = mk(3, 18 + k); pend[3].push_back(b3[k]);
        end
        for (int k = 5; k <= 7; k++) pend[2].push_back(mk(2, k));
        tick();
        tick();
        check("bp_load_not_ready", 64'(bus.src_ready[2]), 64'd0);
        check_port("bp_grant", 0, 1'b1, b3[0]);
        check_port("bp_grant", 1, 1'b1, b0[0]);
        check_port("bp_grant", 2, 1'b1, b1[0]);
        for (int i = 0; i < 30 && outstanding() != 0; i++) tick();
        check("bp_drained", 64'(outstanding()), 64'd0);

        // Flush with buffered entries and a same-cycle push.
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 3; k++) pend[s].push_back(mk(s, 24 + k));
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_cleared("flush");
        tick();
        tick();
        tick();
        for (int s = 0; s < 4; s++) pend[s].push_back(mk(s, 20 + s));
        b0[0] = pend[0][0]; b1[0] = pend[1][0]; t = pend[2][0]; b3[0] = pend[3][0];
        tick();
        tick();
        check_port("post_flush_rr", 0, 1'b1, b0[0]);
        check_port("post_flush_rr", 1, 1'b1, b1[0]);
        check_port("post_flush_rr", 2, 1'b1, t);
        tick();
        check_port("post_flush_rr_b", 0, 1'b1, b3[0]);

        // Fairness between sources 0 and 3; rr_ptr wraps 3 -> 0 every cycle.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 10; k++) begin
            a0[k] = mk(0, k);      pend[0].push_back(a0[k]);
            a3[k] = mk(3, 16 + k); pend[3].push_back(a3[k]);
        end
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            check_port($sformatf("fair%0d", k), 0, 1'b1, a0[k]);
            check_port($sformatf("fair%0d", k), 1, 1'b1, a3[k]);
            check_port($sformatf("fair%0d", k), 2, 1'b0, a3[k]);
        end

        // Reset in the middle of traffic, then behave as from power-up.
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 3; k++) pend[s].push_back(mk(s, 8 + k));
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cleared("mid_reset");
        t = mk(1, 30);
        pend[1].push_back(t);
        tick();
        check_port("after_reset_t", 0, 1'b0, t);
        tick();
        check_port("after_reset_t1", 0, 1'b1, t);
        check_port("after_reset_t1", 1, 1'b0, t);

        for (int i = 0; i < 30 && outstanding() != 0; i++) tick();
        check("final_drained", 64'(outstanding()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
